// File: rtl/uart_rx_word_fifo_pkg.sv
// Shared constants for the UART receive word FIFO: register offsets,
// STATUS/CTRL bit positions, CTRL reset value and AHB transfer encodings.
package uart_rx_fifo_pkg;

  // Register offsets as decoded from HADDR[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  // STATUS bit positions
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_UDF       = 3;
  localparam int ST_RXERR     = 4;
  localparam int ST_PK_LSB    = 5;
  localparam int ST_CNT_LSB   = 8;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ     = 1;
  localparam int CTRL_THR_LSB = 8;
  localparam int CTRL_FLUSH   = 31;

  localparam logic [31:0] CTRL_RESET = 32'h0000_0100;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Word count field is 8 bits wide but a 256-deep FIFO can hold 256 words
  function automatic logic [7:0] sat_u8(input logic [8:0] v);
    return (v > 9'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/uart_rx_word_fifo_if.sv
// AHB-Lite slave-side signal bundle for the UART receive word FIFO.
interface uart_rx_word_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int ADDR_W = 8
) ();
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic [31:0]       HRDATA;
  logic              HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/uart_rx_word_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    if (do_push & ~do_pop) count_d = count_q + 1'b1;
    else if (~do_push & do_pop) count_d = count_q - 1'b1;
  end

  // Storage array; contents are don't-care while empty
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy, cleared by reset or flush
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= AW'(wr_ptr_q + 1'b1);
      if (do_pop)  rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_word_fifo.sv
// UART receive byte packer + word FIFO behind a zero-wait AHB-Lite slave,
// with a thresholded level interrupt (RXRDY).
module uart_rx_word_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [7:0]          RX_DATA,
  input  logic                RX_VALID,
  input  logic                RX_ERR,
  uart_rx_word_fifo_if.slave  ahb,
  output logic                RXRDY
);
  logic        dphase_q, write_q, mapped_q;
  logic [1:0]  reg_q;
  logic        ctrl_en_q, ctrl_en_d, ctrl_irq_q, ctrl_irq_d;
  logic [7:0]  ctrl_thr_q, ctrl_thr_d, thr_eff;
  logic        ovf_q, ovf_d, udf_q, udf_d, rxerr_q, rxerr_d;
  logic [1:0]  pk_cnt_q, pk_cnt_d;
  logic [23:0] pk_word_q, pk_word_d;
  logic        rxrdy_q, rxrdy_d;

  logic        accept, dp_done, rd_data, wr_ctrl, wr_clear, flush;
  logic        byte_ok, byte_err, pack_push, pop, underflow_evt, overflow_evt;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head, status, rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [8:0]  cnt9;
  logic        unused_bits;

  assign accept   = ahb.HSEL & ahb.HREADY &
                    ((ahb.HTRANS == HTRANS_NONSEQ) | (ahb.HTRANS == HTRANS_SEQ));
  assign dp_done  = dphase_q & mapped_q & ahb.HREADY;
  assign rd_data  = dp_done & ~write_q & (reg_q == REG_DATA);
  assign wr_ctrl  = dp_done & write_q & (reg_q == REG_CTRL);
  assign wr_clear = dp_done & write_q & (reg_q == REG_CLEAR);
  assign flush    = wr_ctrl & ahb.HWDATA[CTRL_FLUSH];

  // A byte landing in the flush cycle is dropped along with the packer
  assign byte_ok       = RX_VALID & ctrl_en_q & ~RX_ERR & ~flush;
  assign byte_err      = RX_VALID & ctrl_en_q & RX_ERR & ~flush;
  assign pack_push     = byte_ok & (pk_cnt_q == 2'd3);
  assign pop           = rd_data & ~fifo_empty;
  assign underflow_evt = rd_data & fifo_empty;
  assign overflow_evt  = pack_push & fifo_full & ~pop;

  assign cnt9    = 9'(fifo_count);
  assign thr_eff = (ctrl_thr_q == 8'd0) ? 8'd1 : ctrl_thr_q;

  sync_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .flush_i (flush),
    .push_i  (pack_push),
    .pop_i   (pop),
    .wdata_i ({RX_DATA, pk_word_q}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state for control, stickies, packer and interrupt
  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    ctrl_irq_d = ctrl_irq_q;
    ctrl_thr_d = ctrl_thr_q;
    if (wr_ctrl) begin
      ctrl_en_d  = ahb.HWDATA[CTRL_EN];
      ctrl_irq_d = ahb.HWDATA[CTRL_IRQ];
      ctrl_thr_d = ahb.HWDATA[CTRL_THR_LSB +: 8];
    end
    ovf_d   = (ovf_q   & ~(wr_clear & ahb.HWDATA[ST_OVF]))   | overflow_evt;
    udf_d   = (udf_q   & ~(wr_clear & ahb.HWDATA[ST_UDF]))   | underflow_evt;
    rxerr_d = (rxerr_q & ~(wr_clear & ahb.HWDATA[ST_RXERR])) | byte_err;
    pk_cnt_d  = pk_cnt_q;
    pk_word_d = pk_word_q;
    if (flush) begin
      pk_cnt_d  = 2'd0;
      pk_word_d = '0;
    end else if (byte_ok) begin
      case (pk_cnt_q)
        2'd0:    pk_word_d[7:0]   = RX_DATA;
        2'd1:    pk_word_d[15:8]  = RX_DATA;
        2'd2:    pk_word_d[23:16] = RX_DATA;
        default: ;
      endcase
      pk_cnt_d = pk_cnt_q + 2'd1;
    end
    rxrdy_d = ctrl_irq_q & (cnt9 >= {1'b0, thr_eff});
  end

  // Register update; the address-phase capture only advances when HREADY
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dphase_q   <= 1'b0;
      write_q    <= 1'b0;
      mapped_q   <= 1'b0;
      reg_q      <= 2'd0;
      ctrl_en_q  <= CTRL_RESET[CTRL_EN];
      ctrl_irq_q <= CTRL_RESET[CTRL_IRQ];
      ctrl_thr_q <= CTRL_RESET[CTRL_THR_LSB +: 8];
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rxerr_q    <= 1'b0;
      pk_cnt_q   <= 2'd0;
      pk_word_q  <= '0;
      rxrdy_q    <= 1'b0;
    end else begin
      if (ahb.HREADY) begin
        dphase_q <= accept;
        write_q  <= ahb.HWRITE;
        mapped_q <= (ahb.HADDR[ADDR_W-1:4] == '0);
        reg_q    <= ahb.HADDR[3:2];
      end
      ctrl_en_q  <= ctrl_en_d;
      ctrl_irq_q <= ctrl_irq_d;
      ctrl_thr_q <= ctrl_thr_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rxerr_q    <= rxerr_d;
      pk_cnt_q   <= pk_cnt_d;
      pk_word_q  <= pk_word_d;
      rxrdy_q    <= rxrdy_d;
    end
  end

  // Read mux, driven only during a read data phase
  always_comb begin
    status = '0;
    status[ST_NOT_EMPTY]         = ~fifo_empty;
    status[ST_FULL]              = fifo_full;
    status[ST_OVF]               = ovf_q;
    status[ST_UDF]               = udf_q;
    status[ST_RXERR]             = rxerr_q;
    status[ST_PK_LSB +: 2]       = pk_cnt_q;
    status[ST_CNT_LSB +: 8]      = sat_u8(cnt9);
    rdata = '0;
    if (dphase_q && mapped_q && !write_q) begin
      case (reg_q)
        REG_DATA:   rdata = fifo_empty ? 32'd0 : fifo_head;
        REG_STATUS: rdata = status;
        REG_CTRL: begin
          rdata[CTRL_EN]           = ctrl_en_q;
          rdata[CTRL_IRQ]          = ctrl_irq_q;
          rdata[CTRL_THR_LSB +: 8] = ctrl_thr_q;
        end
        default:    rdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign RXRDY         = rxrdy_q;

  assign unused_bits = ^{ahb.HSIZE, ahb.HADDR[1:0], ahb.HWDATA[30:16], ahb.HWDATA[7:5]};

endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Randomised self-checking bench for uart_rx_word_fifo with a queue-based
// reference model of the packer, FIFO, stickies and interrupt.
module tb_uart_rx_word_fifo;
  localparam int DEPTH = 16;

  logic       HCLK, HRESET;
  logic [7:0] RX_DATA;
  logic       RX_VALID, RX_ERR;
  logic       RXRDY;

  uart_rx_word_fifo_if #(.ADDR_W(8)) bus ();

  uart_rx_word_fifo #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .RX_ERR   (RX_ERR),
    .ahb      (bus.slave),
    .RXRDY    (RXRDY)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_q[$];
  logic [7:0]  m_pk[3];
  int          m_pk_n;
  bit          m_ovf, m_udf, m_err, m_en, m_irq;
  int          m_thr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_pk_n = 0;
    m_ovf = 0; m_udf = 0; m_err = 0;
    m_en = 0; m_irq = 0; m_thr = 1;
  endfunction

  function automatic void model_byte(input logic [7:0] d, input bit err);
    if (!m_en) return;
    if (err) begin
      m_err = 1;
      return;
    end
    if (m_pk_n < 3) begin
      m_pk[m_pk_n] = d;
      m_pk_n++;
    end else begin
      m_pk_n = 0;
      if (m_q.size() >= DEPTH) m_ovf = 1;
      else m_q.push_back({d, m_pk[2], m_pk[1], m_pk[0]});
    end
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    int n;
    n = m_q.size();
    s = 32'd0;
    s[0] = (n != 0);
    s[1] = (n == DEPTH);
    s[2] = m_ovf;
    s[3] = m_udf;
    s[4] = m_err;
    s[6:5] = 2'(m_pk_n);
    s[15:8] = (n > 255) ? 8'd255 : 8'(n);
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] addr);
    if (addr[7:4] != 4'd0) return 32'd0;
    case (addr[3:2])
      2'd0: begin
        if (m_q.size() == 0) begin
          m_udf = 1;
          return 32'd0;
        end
        return m_q.pop_front();
      end
      2'd1: return model_status();
      2'd2: return {16'd0, 8'(m_thr), 6'd0, m_irq, m_en};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_write(input logic [7:0] addr, input logic [31:0] d);
    if (addr[7:4] != 4'd0) return;
    if (addr[3:2] == 2'd2) begin
      m_en  = d[0];
      m_irq = d[1];
      m_thr = int'(d[15:8]);
      if (d[31]) begin
        m_q.delete();
        m_pk_n = 0;
      end
    end else if (addr[3:2] == 2'd3) begin
      if (d[2]) m_ovf = 0;
      if (d[3]) m_udf = 0;
      if (d[4]) m_err = 0;
    end
  endfunction

  function automatic bit model_rxrdy();
    int t;
    t = (m_thr < 1) ? 1 : m_thr;
    return m_irq && (m_q.size() >= t);
  endfunction

  task automatic bus_idle();
    bus.HSEL = 0; bus.HTRANS = 2'b00; bus.HWRITE = 0;
  endtask

  // pipelined burst of n reads from one address; each beat checked
  task automatic ahb_read(input string tag, input logic [7:0] addr, input int n);
    @(posedge HCLK) #1;
    bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HWRITE = 0; bus.HADDR = addr;
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK) #1;
      if (i == n - 1) bus_idle();
      else bus.HTRANS = 2'b11;
      #4;
      check_val(tag, bus.HRDATA, model_read(addr));
    end
  endtask

  task automatic ahb_write(input logic [7:0] addr, input logic [31:0] d);
    @(posedge HCLK) #1;
    bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HWRITE = 1; bus.HADDR = addr;
    @(posedge HCLK) #1;
    bus_idle();
    bus.HWDATA = d;
    model_write(addr, d);
  endtask

  task automatic rx_byte(input logic [7:0] d, input bit err);
    @(posedge HCLK) #1;
    RX_VALID = 1; RX_DATA = d; RX_ERR = err;
    model_byte(d, err);
    @(posedge HCLK) #1;
    RX_VALID = 0; RX_ERR = 0;
  endtask

  // DATA read whose data phase coincides with a completing byte
  task automatic read_with_push(input string tag, input logic [7:0] b);
    @(posedge HCLK) #1;
    bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HWRITE = 0; bus.HADDR = 8'h00;
    @(posedge HCLK) #1;
    bus_idle();
    RX_VALID = 1; RX_DATA = b; RX_ERR = 0;
    #4;
    check_val(tag, bus.HRDATA, model_read(8'h00));
    model_byte(b, 0);
    @(posedge HCLK) #1;
    RX_VALID = 0;
  endtask

  task automatic settle_rxrdy(input string tag);
    repeat (3) @(posedge HCLK);
    #1;
    check_val(tag, {31'd0, RXRDY}, {31'd0, model_rxrdy()});
  endtask

  initial begin
    logic [7:0] addr_tbl[6];
    logic [7:0] a;
    int op;

    addr_tbl[0] = 8'h00; addr_tbl[1] = 8'h04; addr_tbl[2] = 8'h08;
    addr_tbl[3] = 8'h0C; addr_tbl[4] = 8'h10; addr_tbl[5] = 8'h44;

    RX_VALID = 0; RX_ERR = 0; RX_DATA = 0;
    bus_idle();
    bus.HADDR = 0; bus.HSIZE = 3'd2; bus.HWDATA = 0; bus.HREADY = 1;
    HRESET = 1;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1 HRESET = 0;
    #3;
    check_val("rst_rxrdy", {31'd0, RXRDY}, 32'd0);
    check_val("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
    check_val("rst_hresp", {31'd0, bus.HRESP}, 32'd0);
    check_val("rst_hrdata", bus.HRDATA, 32'd0);
    ahb_read("rst_status", 8'h04, 1);
    ahb_read("rst_ctrl", 8'h08, 1);

    // basic packing and interrupt timing
    ahb_write(8'h08, 32'h0000_0103);
    rx_byte(8'h11, 0); rx_byte(8'h22, 0); rx_byte(8'h33, 0); rx_byte(8'h44, 0);
    check_val("rxrdy_push_same", {31'd0, RXRDY}, 32'd0);
    @(posedge HCLK) #1;
    check_val("rxrdy_push_next", {31'd0, RXRDY}, 32'd1);
    ahb_read("status_one", 8'h04, 1);
    ahb_read("data_first", 8'h00, 1);
    @(posedge HCLK) #1;
    check_val("rxrdy_pop_same", {31'd0, RXRDY}, 32'd1);
    @(posedge HCLK) #1;
    check_val("rxrdy_pop_next", {31'd0, RXRDY}, 32'd0);

    // threshold 4
    ahb_write(8'h08, 32'h0000_0403);
    for (int i = 0; i < 12; i++) rx_byte(8'($urandom), 0);
    settle_rxrdy("rxrdy_thr_below");
    for (int i = 0; i < 4; i++) rx_byte(8'($urandom), 0);
    settle_rxrdy("rxrdy_thr_at");
    ahb_read("data_burst4", 8'h00, 4);
    settle_rxrdy("rxrdy_thr_drained");

    // overflow
    ahb_write(8'h08, 32'h0000_0103);
    for (int i = 0; i < 4 * DEPTH + 4; i++) rx_byte(8'($urandom), 0);
    ahb_read("status_ovf", 8'h04, 1);
    ahb_write(8'h0C, 32'h0000_0004);
    ahb_read("status_ovf_clr", 8'h04, 1);
    for (int i = 0; i < 3; i++) rx_byte(8'($urandom), 0);
    read_with_push("data_full_pushpop", 8'($urandom));
    ahb_read("status_full_pushpop", 8'h04, 1);
    ahb_read("data_drain", 8'h00, DEPTH);
    ahb_read("data_empty", 8'h00, 1);
    ahb_read("status_udf", 8'h04, 1);
    for (int i = 0; i < 3; i++) rx_byte(8'($urandom), 0);
    read_with_push("data_empty_push", 8'($urandom));
    ahb_read("status_empty_push", 8'h04, 1);

    // error byte and flush
    ahb_write(8'h0C, 32'h0000_001C);
    rx_byte(8'hAA, 0); rx_byte(8'hBB, 1); rx_byte(8'hCC, 0);
    ahb_read("status_rxerr", 8'h04, 1);
    ahb_write(8'h08, 32'h8000_0103);
    ahb_read("status_flush", 8'h04, 1);
    ahb_read("ctrl_flush_rd0", 8'h08, 1);

    // unmapped accesses
    ahb_write(8'h18, 32'hFFFF_FFFF);
    ahb_read("unmapped_rd", 8'h18, 1);
    ahb_read("clear_rd", 8'h0C, 1);

    // randomised mix
    for (int it = 0; it < 300; it++) begin
      op = int'($urandom_range(0, 9));
      a  = addr_tbl[$urandom_range(0, 5)];
      if (op <= 5) rx_byte(8'($urandom), ($urandom_range(0, 7) == 0));
      else if (op <= 7) ahb_read("rand_rd", a, int'($urandom_range(1, 3)));
      else if (op == 8) ahb_write(8'h08, {($urandom_range(0, 15) == 0), 15'd0,
                                          8'($urandom_range(0, 6)), 6'd0,
                                          1'($urandom), ($urandom_range(0, 7) != 0)});
      else ahb_write(a, $urandom);
      if ((it % 10) == 9) begin
        settle_rxrdy("rand_rxrdy");
        ahb_read("rand_status", 8'h04, 1);
      end
    end

    // reset during a pending read data phase
    ahb_write(8'h08, 32'h8000_0103);
    ahb_write(8'h0C, 32'h0000_001C);
    for (int i = 0; i < 12; i++) rx_byte(8'($urandom), 0);
    settle_rxrdy("rxrdy_before_rst");
    @(posedge HCLK) #1;
    bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HWRITE = 0; bus.HADDR = 8'h00;
    @(posedge HCLK) #1;
    bus_idle();
    HRESET = 1;
    @(posedge HCLK) #1;
    HRESET = 0;
    model_reset();
    #2;
    check_val("midrst_rxrdy", {31'd0, RXRDY}, 32'd0);
    check_val("midrst_hrdata", bus.HRDATA, 32'd0);
    ahb_read("midrst_status", 8'h04, 1);
    ahb_read("midrst_ctrl", 8'h08, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
